// File: rtl/ahb_mtx_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_pkg
// Shared definitions for the AHB matrix arbiter slice:
//   - HTRANS transfer-type encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - HBURST burst-type encodings
//   - beat-counter width and "beats remaining after NONSEQ" constants
//   - burst_beats_left(): maps an HBURST code to the counter load value,
//     zero for bursts with no fixed length (SINGLE, INCR)
// ---------------------------------------------------------------------------
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    localparam int BEAT_CNT_W = 4;

    // The NONSEQ beat is the first beat, so the counter holds the number
    // of SEQ beats still to come.
    localparam logic [BEAT_CNT_W-1:0] BEATS_LEFT_4  = 4'd3;
    localparam logic [BEAT_CNT_W-1:0] BEATS_LEFT_8  = 4'd7;
    localparam logic [BEAT_CNT_W-1:0] BEATS_LEFT_16 = 4'd15;

    function automatic logic [BEAT_CNT_W-1:0] burst_beats_left(input logic [2:0] hburst);
        case (hburst_t'(hburst))
            HBURST_WRAP4,  HBURST_INCR4:  return BEATS_LEFT_4;
            HBURST_WRAP8,  HBURST_INCR8:  return BEATS_LEFT_8;
            HBURST_WRAP16, HBURST_INCR16: return BEATS_LEFT_16;
            default:                      return '0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mtx_burst_cnt.sv
// ---------------------------------------------------------------------------
// ahb_mtx_burst_cnt
// Beat counter for fixed-length AHB bursts. While a WRAPx/INCRx burst is in
// flight the arbiter must not re-arbitrate; this block tells it so.
//
// Ports:
//   HCLK        in   system clock, rising edge
//   HRESETn     in   asynchronous active-low reset
//   HREADYM     in   transfer done; counter only moves when high
//   HSELM       in   slave select of the granted port
//   HTRANSM[1:0] in  transfer type of the granted port
//   HBURSTM[2:0] in  burst type of the granted port
//   burst_hold  out  1 = keep the current grant this cycle
// ---------------------------------------------------------------------------
module ahb_mtx_burst_cnt
    import ahb_mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       burst_hold
);

    logic [BEAT_CNT_W-1:0] cnt_q;
    logic [BEAT_CNT_W-1:0] cnt_d;
    logic [BEAT_CNT_W-1:0] load_val;
    logic                  early_end;

    // Next counter value and hold flag. Deselect, IDLE or an undefined-length
    // NONSEQ ends the burst early, and that drops the hold in the same cycle
    // so the arbiter can hand over on this very edge.
    always_comb begin
        load_val  = burst_beats_left(HBURSTM);
        early_end = !HSELM
                    || (HTRANSM == HTRANS_IDLE)
                    || ((HTRANSM == HTRANS_NONSEQ) && (load_val == '0));
        cnt_d     = cnt_q;
        if (!HSELM) begin
            cnt_d = '0;
        end else begin
            case (htrans_t'(HTRANSM))
                HTRANS_IDLE:   cnt_d = '0;
                HTRANS_BUSY:   cnt_d = cnt_q;
                HTRANS_NONSEQ: cnt_d = load_val;
                HTRANS_SEQ:    cnt_d = (cnt_q != '0) ? (cnt_q - BEAT_CNT_W'(1)) : cnt_q;
                default:       cnt_d = '0;
            endcase
        end
        burst_hold = (cnt_q != '0) && !early_end;
    end

    // Counter register; a wait-stated cycle freezes it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else if (HREADYM) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_mtx_arb_param.sv
// ---------------------------------------------------------------------------
// ahb_mtx_arb_param
// Parameterised arbiter selecting which input port drives a shared AHB
// slave. Fixed priority (ARB_MODE=0, port 0 highest) or round robin
// (ARB_MODE=1). Grant only moves on HREADYM-qualified edges.
//
// Build option: define AHB_ARB_BURST_HOLD_EN to keep the grant for the
// whole of a fixed-length burst (WRAP4/INCR4/.../INCR16). Without it the
// grant may change on any beat and HBURSTM is ignored.
//
// Parameters:
//   NUM_PORTS  number of ports, 2..16
//   PORT_W     port index width, 2**PORT_W >= NUM_PORTS
//   ARB_MODE   0 = fixed priority, 1 = round robin
//
// Ports:
//   HCLK                   in   system clock, rising edge
//   HRESETn                in   asynchronous active-low reset
//   req_port[NUM_PORTS-1:0] in  per-port request
//   HREADYM                in   transfer done on the shared slave
//   HSELM                  in   slave select of the granted port
//   HTRANSM[1:0]           in   transfer type of the granted port
//   HBURSTM[2:0]           in   burst type of the granted port
//   HMASTLOCKM             in   locked transfer, freezes the grant
//   addr_in_port[PORT_W-1:0] out granted port index (registered)
//   no_port                out  no port selected (registered)
// ---------------------------------------------------------------------------
module ahb_mtx_arb_param
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 4,
    parameter int ARB_MODE  = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    localparam logic [PORT_W:0] NUM_PORTS_EXT = (PORT_W+1)'(NUM_PORTS);

    logic [PORT_W-1:0]      addr_q;
    logic [PORT_W-1:0]      addr_d;
    logic                   no_q;
    logic                   no_d;
    logic [PORT_W-1:0]      rr_q;
    logic [PORT_W-1:0]      rr_d;
    logic                   burst_hold;

    logic [NUM_PORTS-1:0]   qual;
    logic [2*NUM_PORTS-1:0] qual_dbl;
    logic [NUM_PORTS-1:0]   qual_rot;
    logic                   fp_found;
    logic [PORT_W-1:0]      fp_win;
    logic [PORT_W-1:0]      rr_off;
    logic [PORT_W:0]        rr_sum;
    logic [PORT_W-1:0]      rr_win;
    logic [PORT_W:0]        inc_sum;
    logic [PORT_W-1:0]      win_next;
    logic                   any_qual;
    logic [PORT_W-1:0]      win;

`ifdef AHB_ARB_BURST_HOLD_EN
    ahb_mtx_burst_cnt u_burst_cnt (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HREADYM    (HREADYM),
        .HSELM      (HSELM),
        .HTRANSM    (HTRANSM),
        .HBURSTM    (HBURSTM),
        .burst_hold (burst_hold)
    );
`else
    logic unused_hburst;
    assign burst_hold    = 1'b0;
    assign unused_hburst = ^HBURSTM;
`endif

    // Which ports may win: anyone requesting, plus the port that already
    // owns the bus while it is still mid-transfer. A port counts as
    // "current" only while something is actually granted.
    always_comb begin
        qual = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            qual[i] = req_port[i]
                      | (!no_q && HSELM && (HTRANSM != HTRANS_IDLE)
                         && (addr_q == PORT_W'(i)));
        end
    end

    // Both priority searches are built every cycle and ARB_MODE picks one.
    // Round robin rotates the qualifier vector so the pointer position
    // becomes bit 0, finds the lowest set bit, then adds the pointer back
    // modulo NUM_PORTS.
    always_comb begin
        fp_found = 1'b0;
        fp_win   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                fp_found = 1'b1;
                fp_win   = PORT_W'(i);
            end
        end

        qual_dbl = {qual, qual} >> rr_q;
        qual_rot = qual_dbl[NUM_PORTS-1:0];
        rr_off   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (qual_rot[k]) begin
                rr_off = PORT_W'(k);
            end
        end
        rr_sum = {1'b0, rr_q} + {1'b0, rr_off};
        if (rr_sum >= NUM_PORTS_EXT) begin
            rr_sum = rr_sum - NUM_PORTS_EXT;
        end
        rr_win = rr_sum[PORT_W-1:0];

        any_qual = fp_found;
        win      = (ARB_MODE == 1) ? rr_win : fp_win;

        inc_sum = {1'b0, win} + (PORT_W+1)'(1);
        if (inc_sum >= NUM_PORTS_EXT) begin
            inc_sum = '0;
        end
        win_next = inc_sum[PORT_W-1:0];
    end

    // Next-grant decision: a locked transfer or an active burst freezes the
    // grant; otherwise arbitrate. With nobody qualifying, an asserted select
    // keeps the current owner, a deasserted one parks on "no port" without
    // disturbing the remembered index.
    always_comb begin
        addr_d = addr_q;
        no_d   = no_q;
        rr_d   = rr_q;
        if (HMASTLOCKM || burst_hold) begin
            addr_d = addr_q;
        end else if (any_qual) begin
            addr_d = win;
            no_d   = 1'b0;
            if ((ARB_MODE == 1) && (no_q || (win != addr_q))) begin
                rr_d = win_next;
            end
        end else begin
            no_d = !HSELM;
        end
    end

    // Grant, idle flag and round-robin pointer; wait states freeze them.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            no_q   <= 1'b1;
            rr_q   <= '0;
        end else if (HREADYM) begin
            addr_q <= addr_d;
            no_q   <= no_d;
            rr_q   <= rr_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_q;

endmodule

// File: tb/tb_ahb_mtx_arb_param.sv
// ---------------------------------------------------------------------------
// tb_ahb_mtx_arb_param
// Drives a fixed-priority and a round-robin instance from the same inputs
// and compares both against a behavioural model of the arbitration rules,
// with directed scenarios followed by randomized traffic.
// Build with AHB_ARB_BURST_HOLD_EN defined to exercise the burst hold.
// ---------------------------------------------------------------------------
module tb_ahb_mtx_arb_param;

    localparam int N  = 4;
    localparam int PW = 4;

    logic          HCLK;
    logic          HRESETn;
    logic [N-1:0]  req_port;
    logic          HREADYM;
    logic          HSELM;
    logic [1:0]    HTRANSM;
    logic [2:0]    HBURSTM;
    logic          HMASTLOCKM;
    logic [PW-1:0] addr_fp;
    logic          none_fp;
    logic [PW-1:0] addr_rr;
    logic          none_rr;

    int compared;
    int mismatched;

    // Model state, index 0 = fixed priority, 1 = round robin.
    int mGrant[2];
    int mNone[2];
    int mRr[2];
    int mBeats[2];

    ahb_mtx_arb_param #(.NUM_PORTS(N), .PORT_W(PW), .ARB_MODE(0)) dut_fp (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_fp),
        .no_port      (none_fp)
    );

    ahb_mtx_arb_param #(.NUM_PORTS(N), .PORT_W(PW), .ARB_MODE(1)) dut_rr (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_rr),
        .no_port      (none_rr)
    );

    // Free-running 10-unit clock.
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // The one place comparisons are made and counted.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int m = 0; m < 2; m++) begin
            mGrant[m] = 0;
            mNone[m]  = 1;
            mRr[m]    = 0;
            mBeats[m] = 0;
        end
    endfunction

    // One HCLK edge of the arbitration rules for instance m, read straight
    // from the current input values.
    function automatic void modelStep(input int m);
        bit holdNow;
        int nextBeats;
        int win;
        int p;
        int t;
        bit qualifies;
`ifdef AHB_ARB_BURST_HOLD_EN
        int b;
        int len;
        bit endEarly;
`endif
        if (!HREADYM) return;
        holdNow   = 1'b0;
        nextBeats = mBeats[m];
        t         = int'(HTRANSM);
`ifdef AHB_ARB_BURST_HOLD_EN
        b        = int'(HBURSTM);
        len      = (b >= 2) ? (4 << ((b >> 1) - 1)) : 0;
        endEarly = !HSELM || (t == 0) || ((t == 2) && (len == 0));
        holdNow  = (mBeats[m] != 0) && !endEarly;
        if (!HSELM || t == 0)               nextBeats = 0;
        else if (t == 2)                    nextBeats = (len == 0) ? 0 : len - 1;
        else if (t == 3 && mBeats[m] > 0)   nextBeats = mBeats[m] - 1;
`endif
        if (!(HMASTLOCKM || holdNow)) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                p = (m == 1) ? (mRr[m] + k) % N : k;
                qualifies = req_port[p]
                            || (mNone[m] == 0 && p == mGrant[m] && HSELM && t != 0);
                if (win < 0 && qualifies) win = p;
            end
            if (win >= 0) begin
                if (m == 1 && (mNone[m] != 0 || win != mGrant[m])) mRr[m] = (win + 1) % N;
                mGrant[m] = win;
                mNone[m]  = 0;
            end else begin
                mNone[m] = HSELM ? 0 : 1;
            end
        end
        mBeats[m] = nextBeats;
    endfunction

    // Present one cycle of inputs, let an edge pass, then compare both
    // instances against the model just after the edge.
    task automatic applyStimulus(input string tag, input logic [N-1:0] req,
                                 input bit ready, input bit sel,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input bit lock);
        req_port   = req;
        HREADYM    = ready;
        HSELM      = sel;
        HTRANSM    = trans;
        HBURSTM    = burst;
        HMASTLOCKM = lock;
        @(posedge HCLK);
        #1;
        modelStep(0);
        modelStep(1);
        checkOutput({tag, "_fp_grant"}, addr_fp, mGrant[0]);
        checkOutput({tag, "_fp_none"},  none_fp, mNone[0]);
        checkOutput({tag, "_rr_grant"}, addr_rr, mGrant[1]);
        checkOutput({tag, "_rr_none"},  none_rr, mNone[1]);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic doReset();
        #2;
        HRESETn = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_fp_grant", addr_fp, 0);
        checkOutput("rst_fp_none",  none_fp, 1);
        checkOutput("rst_rr_grant", addr_rr, 0);
        checkOutput("rst_rr_none",  none_rr, 1);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    // Directed scenarios first, then random traffic with occasional resets.
    initial begin
        compared   = 0;
        mismatched = 0;
        HRESETn    = 1'b0;
        req_port   = '0;
        HREADYM    = 1'b0;
        HSELM      = 1'b0;
        HTRANSM    = 2'b00;
        HBURSTM    = 3'b000;
        HMASTLOCKM = 1'b0;
        modelReset();
        #12;
        checkOutput("por_fp_grant", addr_fp, 0);
        checkOutput("por_fp_none",  none_fp, 1);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Idle bus after reset stays parked.
        for (int i = 0; i < 3; i++) applyStimulus("idle", 4'b0000, 1, 0, 2'b00, 3'b000, 0);
        checkOutput("idle_grant", addr_fp, 0);
        checkOutput("idle_none",  none_fp, 1);

        // Fixed priority: port 1 beats port 3, then 3 takes over once 1 goes idle.
        applyStimulus("fp1", 4'b1010, 1, 0, 2'b00, 3'b000, 0);
        checkOutput("fp_pick1", addr_fp, 1);
        applyStimulus("fp3", 4'b1000, 1, 1, 2'b00, 3'b000, 0);
        checkOutput("fp_pick3", addr_fp, 3);

        // Round robin rotation from a fresh pointer.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus("rr", 4'b1111, 1, 0, 2'b00, 3'b000, 0);
            checkOutput("rr_seq", addr_rr, i % N);
        end

        // Lock on port 3 ignores port 0; wait state freezes everything.
        applyStimulus("lk0", 4'b1000, 1, 0, 2'b00, 3'b000, 0);
        applyStimulus("lk1", 4'b0001, 1, 1, 2'b10, 3'b000, 1);
        applyStimulus("lk2", 4'b0001, 1, 1, 2'b11, 3'b000, 1);
        checkOutput("lock_fp", addr_fp, 3);
        checkOutput("lock_rr", addr_rr, 3);
        applyStimulus("ws", 4'b0001, 0, 1, 2'b00, 3'b000, 0);
        checkOutput("wait_fp", addr_fp, 3);
        applyStimulus("unlk", 4'b0001, 1, 1, 2'b00, 3'b000, 0);
        checkOutput("unlock_fp", addr_fp, 0);

        // Port 2 INCR4; port 0 asks from the first SEQ beat onward.
        applyStimulus("b4g", 4'b0100, 1, 0, 2'b00, 3'b000, 0);
        applyStimulus("b4n", 4'b0000, 1, 1, 2'b10, 3'b011, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("b4s", 4'b0001, 1, 1, 2'b11, 3'b011, 0);
`ifdef AHB_ARB_BURST_HOLD_EN
            checkOutput("burst4_hold", addr_fp, 2);
`endif
        end
        applyStimulus("b4e", 4'b0001, 1, 1, 2'b00, 3'b000, 0);
        checkOutput("burst4_end", addr_fp, 0);

        // Port 1 INCR8 cut short by IDLE after two beats.
        applyStimulus("b8g", 4'b0010, 1, 0, 2'b00, 3'b000, 0);
        applyStimulus("b8n", 4'b0000, 1, 1, 2'b10, 3'b101, 0);
        applyStimulus("b8s", 4'b0001, 1, 1, 2'b11, 3'b101, 0);
`ifdef AHB_ARB_BURST_HOLD_EN
        checkOutput("burst8_hold", addr_fp, 1);
`endif
        applyStimulus("b8i", 4'b0001, 1, 1, 2'b00, 3'b101, 0);
        checkOutput("burst8_term", addr_fp, 0);

        // Random traffic, biased toward active transfers.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) doReset();
            applyStimulus("rand",
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 4) != 0),
                          2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_arb_param.md
AHB_MTX_ARB_PARAM -- requirements
Module: ahb_mtx_arb_param

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of input ports arbitrated, legal range 2..16.
REQ-002 Parameter PORT_W, default 4: width of port index, SHALL satisfy 2**PORT_W >= NUM_PORTS.
REQ-003 Parameter ARB_MODE, default 0: 0 = fixed priority (port 0 highest), 1 = round robin.
REQ-004 HCLK  input  1  AHB system clock; the single clock, all state on rising edge.
REQ-005 HRESETn  input  1  AHB system reset, asynchronous, active-low.
REQ-006 req_port  input  NUM_PORTS  per-port request, bit i = port i.
REQ-007 HREADYM  input  1  transfer done on the shared slave.
REQ-008 HSELM  input  1  slave select of the currently granted port.
REQ-009 HTRANSM  input  2  transfer type of the currently granted port.
REQ-010 HBURSTM  input  3  burst type of the currently granted port.
REQ-011 HMASTLOCKM  input  1  locked transfer.
REQ-012 addr_in_port  output  PORT_W  index of granted port (registered).
REQ-013 no_port  output  1  no port selected (registered).

Function
REQ-014 State (addr_in_port, no_port, beat counter, rr pointer) SHALL update only on HCLK rising edges with HREADYM=1; HREADYM=0 holds all state.
REQ-015 Priority of next-grant decision: HMASTLOCKM=1 -> keep current; else burst hold active -> keep current; else arbitration.
REQ-016 Arbitration: a port qualifies if its req bit is 1, or it is the current port with HSELM=1 and HTRANSM!=IDLE; winner = highest-priority qualifier.
REQ-017 ARB_MODE=0: priority order port 0, 1, ..., NUM_PORTS-1.
REQ-018 ARB_MODE=1: search starts at (rr pointer), wraps modulo NUM_PORTS; rr pointer SHALL load (winner+1) mod NUM_PORTS whenever a new winner differs from the current port.
REQ-019 No qualifier and HSELM=1: keep current port, no_port=0; no qualifier and HSELM=0: no_port=1, addr_in_port unchanged.
REQ-020 Requests with bit index >= NUM_PORTS do not exist; addr_in_port SHALL never exceed NUM_PORTS-1.
REQ-021 Grant change latency: exactly one HREADYM-qualified edge after request is presented.

Reset
REQ-022 On HRESETn low: addr_in_port=0, no_port=1, beat counter=0, rr pointer=0, immediately and independent of HCLK.
REQ-023 Reset asserted mid-burst or mid-lock SHALL abandon hold; first post-reset arbitration follows REQ-016.

Configuration
REQ-024 Macro AHB_ARB_BURST_HOLD_EN defined: fixed-length burst hold logic compiled in (REQ-025..REQ-027).
REQ-025 On accepted NONSEQ with HBURSTM in {WRAP4,INCR4}/{WRAP8,INCR8}/{WRAP16,INCR16}, counter loads 3/7/15; each accepted SEQ decrements; hold active while counter!=0.
REQ-026 BUSY leaves counter unchanged; IDLE, NONSEQ without fixed burst, or HSELM=0 clears counter (early termination), ending hold same cycle.
REQ-027 Macro undefined: no counter, hold never active, arbitration may occur on any beat (legacy behaviour); HBURSTM unused.

Structure
REQ-028 Shared package ahb_mtx_pkg SHALL hold HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HBURST encodings, and beat-count lookup constants.
REQ-029 One sub-module ahb_mtx_burst_cnt (beat counter, hold flag), instantiated only under AHB_ARB_BURST_HOLD_EN.

Verification (NUM_PORTS=4)
REQ-030 Reset release, req_port=0000, HSELM=0 -> addr_in_port=0, no_port=1 held.
REQ-031 ARB_MODE=0, req_port=1010, HREADYM=1 -> addr_in_port=1 next edge; then req_port=1000, current port IDLE -> addr_in_port=3.
REQ-032 ARB_MODE=1, all req=1111 for 4 edges -> grants 0,1,2,3 then wraps to 0.
REQ-033 Burst hold enabled, port 2 INCR4 NONSEQ + 3 SEQ, req_port bit0 raised at beat 1 -> grant stays 2 until last SEQ accepted, then 0.
REQ-034 HMASTLOCKM=1 on port 3, req_port=0001 -> addr_in_port stays 3; HREADYM=0 on any edge -> no state change.
REQ-035 Port 1 INCR8 terminated with IDLE after 2 beats, req_port=0001 -> counter clears, grant moves to 0 next HREADYM edge.
